// File: rtl/pc_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package pc_fetch_pkg;

    typedef enum logic [2:0] {
        FS_BOOT,
        FS_FETCH,
        FS_WAIT,
        FS_VALID,
        FS_ERR
    } fetch_state_e;

    localparam logic [31:0] NOP              = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] align_word(input logic [31:0] a);
        return a & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_fetch_pc_reg.sv
// Architectural PC register: synchronous reset to RESET_PC, load on ld.
module pc_reg
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_PC;
        else if (ld)
            q <= d;
    end

endmodule

// File: rtl/pc_fetch.sv
// Fetch stage: PC register, single-outstanding imem handshake, instruction register.
// Optional PC_ALIGN_CHECK_EN traps misaligned retire targets into a sticky ERR state.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] npc,
    input  logic        npc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic        fetch_err
);

    fetch_state_e state;
    logic         retire;
    logic         pc_ld;
    logic [31:0]  pc_d;

    assign retire = (state == FS_VALID) && npc_en;

`ifdef PC_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = (npc[1:0] != 2'b00);
    assign pc_ld      = retire && !misaligned;
    assign pc_d       = npc;
`else
    assign pc_ld      = retire;
    assign pc_d       = align_word(npc);
    assign fetch_err  = 1'b0;
`endif

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .ld  (pc_ld),
        .d   (pc_d),
        .q   (pc)
    );

    assign imem_addr = pc;

    // imem_req is registered: raised on every entry into FETCH, dropped on grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FS_BOOT;
            inst       <= NOP;
            inst_valid <= 1'b0;
            imem_req   <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            fetch_err  <= 1'b0;
`endif
        end else begin
            case (state)
                FS_BOOT: begin
                    state    <= FS_FETCH;
                    imem_req <= 1'b1;
                end
                FS_FETCH: begin
                    if (imem_gnt) begin
                        state    <= FS_WAIT;
                        imem_req <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        state      <= FS_VALID;
                    end
                end
                FS_VALID: begin
                    if (npc_en) begin
                        inst_valid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                        if (misaligned) begin
                            fetch_err <= 1'b1;
                            state     <= FS_ERR;
                        end else begin
                            state    <= FS_FETCH;
                            imem_req <= 1'b1;
                        end
`else
                        state    <= FS_FETCH;
                        imem_req <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch.sv
// Randomized scoreboard bench for pc_fetch; the bench plays instruction memory.
// Honours PC_ALIGN_CHECK_EN to select the expected misaligned-retire behaviour.
module tb_pc_fetch;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] npc = '0;
    logic        npc_en = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        fetch_err;

    pc_fetch #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .npc_en      (npc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .pc          (pc),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    logic        prev_valid = 1'b0;
    logic [31:0] model_pc = RST_PC;
    int          checks = 0;
    int          passes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passes++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Monitor: each new inst_valid pops one expected capture; while valid, inst/pc must hold.
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (inst_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_inst: got inst_valid=1 with no fetch outstanding, expected 0");
                end else begin
                    cur = sb.pop_front();
                    chk("inst", inst, cur.inst);
                    chk("inst_pc", pc, cur.pc);
                end
            end else if (inst_valid) begin
                chk("inst_hold", inst, cur.inst);
                chk("pc_hold", pc, cur.pc);
            end
            prev_valid = inst_valid;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input int gnt_dly, input int rv_dly, input logic [31:0] data);
        int n = 0;
        while (!imem_req && n < 8) begin
            step();
            n++;
        end
        chk("req_seen", imem_req, 1);
        for (int i = 0; i < gnt_dly; i++) begin
            chk("req_hold", imem_req, 1);
            chk("addr_hold", imem_addr, model_pc);
            npc         = $urandom;
            npc_en      = 1'($urandom_range(0, 1));
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            step();
        end
        chk("addr", imem_addr, model_pc);
        npc_en      = 1'b0;
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("req_drop", imem_req, 0);
        for (int i = 0; i < rv_dly; i++) begin
            npc    = $urandom;
            npc_en = 1'($urandom_range(0, 1));
            step();
            chk("no_req_wait", imem_req, 0);
            chk("pc_wait", pc, model_pc);
        end
        npc_en      = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        sb.push_back('{pc: model_pc, inst: data});
        step();
        imem_rvalid = 1'b0;
        chk("valid", inst_valid, 1);
    endtask

    task automatic retire(input int hold, input logic [31:0] target);
        for (int i = 0; i < hold; i++) begin
            imem_rvalid = 1'($urandom_range(0, 1));
            imem_rdata  = $urandom;
            step();
            chk("valid_hold", inst_valid, 1);
            chk("no_req_valid", imem_req, 0);
        end
        imem_rvalid = 1'b0;
        npc         = target;
        npc_en      = 1'b1;
        step();
        npc_en   = 1'b0;
        model_pc = target & ~32'h3;
        chk("retire_valid", inst_valid, 0);
        chk("retire_pc", pc, model_pc);
        chk("retire_req", imem_req, 1);
        chk("retire_addr", imem_addr, model_pc);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] r;
        r = $urandom;
`ifdef PC_ALIGN_CHECK_EN
        r[1:0] = 2'b00;
`endif
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFC;
            2:       return 32'h0000_0004;
            default: return r;
        endcase
    endfunction

    task automatic reset_checks(input string tag);
        chk({tag, "_pc"}, pc, RST_PC);
        chk({tag, "_inst"}, inst, NOP_WORD);
        chk({tag, "_valid"}, inst_valid, 0);
        chk({tag, "_req"}, imem_req, 0);
        chk({tag, "_err"}, fetch_err, 0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset");

        // BOOT then FETCH: first request one cycle after release
        rst = 1'b0;
        step();
        chk("boot_req", imem_req, 1);
        chk("boot_addr", imem_addr, RST_PC);

        fetch_one(0, 0, 32'h0050_0093);
        retire(0, 32'h0000_0004);

        fetch_one(3, 2, $urandom);
        retire(1, pick_target());

        repeat (30) begin
            fetch_one($urandom_range(0, 3), $urandom_range(0, 2), $urandom);
            retire($urandom_range(0, 2), pick_target());
        end

        fetch_one(0, 0, $urandom);
`ifdef PC_ALIGN_CHECK_EN
        npc    = 32'h0000_0102;
        npc_en = 1'b1;
        step();
        npc_en = 1'b0;
        chk("err_flag", fetch_err, 1);
        chk("err_valid", inst_valid, 0);
        chk("err_pc", pc, model_pc);
        repeat (5) begin
            npc      = 32'h0000_0200;
            npc_en   = 1'($urandom_range(0, 1));
            imem_gnt = 1'($urandom_range(0, 1));
            step();
            chk("err_no_req", imem_req, 0);
            chk("err_sticky", fetch_err, 1);
        end
        npc_en   = 1'b0;
        imem_gnt = 1'b0;
        rst      = 1'b1;
        step();
        reset_checks("err_reset");
        rst = 1'b0;
        step();
        model_pc = RST_PC;
`else
        retire(0, 32'h0000_0102);
        chk("misalign_pc", pc, 32'h0000_0100);
`endif

        // Reset while WAITing, with the response arriving in the reset cycle
        fetch_one(0, 0, $urandom);
        retire(0, 32'h0000_0200);
        chk("pre_wait_req", imem_req, 1);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("wait_entered", imem_req, 0);
        rst         = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        reset_checks("wait_reset");
        rst = 1'b0;
        step();
        model_pc = RST_PC;
        chk("rerun_req", imem_req, 1);
        chk("rerun_addr", imem_addr, RST_PC);

        fetch_one(1, 1, $urandom);
        @(negedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        checks++;
        $display("FAIL timeout: got no end of test, expected completion");
        $display("%0d/%0d checks passed", passes, checks);
        $fatal(1, "timeout");
    end

endmodule
